alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width.
REQ-002 SHALL have parameter OPW, default 4, ALU opcode width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester i has an operation pending.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  requester i's operation accepted this cycle.
REQ-007 SHALL have ports req0_a/req1_a, req0_b/req1_b  input  DW  operands A and B of requester i.
REQ-008 SHALL have ports req0_op/req1_op  input  OPW  ALU opcode of requester i, passed through uninterpreted.
REQ-009 SHALL have ports alu_a, alu_b  output  DW, and alu_op  output  OPW, driving the shared combinational ALU.
REQ-010 SHALL have ports alu_c  input  DW, and alu_f  input  1, the ALU result and branch flag.
REQ-011 SHALL have port rsp_valid  output  1  result register holds a result.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes the result this cycle.
REQ-013 SHALL have ports rsp_c  output  DW, rsp_f  output  1, and rsp_id  output  1 (0 = req0, 1 = req1).

Function
REQ-014 SHALL hold a single-entry result register with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 SHALL define can_accept = EMPTY, or FULL with rsp_ready=1 in the same cycle (drain and refill in one cycle).
REQ-016 SHALL grant at most one requester per cycle; grant occurs only when can_accept=1 and that requester's valid=1.
REQ-017 SHALL grant the sole valid requester when only one is valid, regardless of the priority pointer.
REQ-018 SHALL grant the requester named by a 1-bit priority pointer when both are valid.
REQ-019 SHALL set the pointer to the non-granted index after every grant and leave it unchanged in cycles with no grant.
REQ-020 SHALL assert reqi_ready combinationally in the grant cycle only; a transfer occurs when reqi_valid and reqi_ready are both 1.
REQ-021 SHALL drive alu_a/alu_b/alu_op from the granted requester in the grant cycle and drive all zeros when there is no grant.
REQ-022 SHALL capture alu_c, alu_f and the granted index into rsp_c/rsp_f/rsp_id at the grant edge, making rsp_valid=1 the next cycle (latency 1).
REQ-023 SHALL hold rsp_c/rsp_f/rsp_id stable while FULL and rsp_ready=0.
REQ-024 SHALL go FULL to EMPTY when rsp_ready=1 with no grant, and stay FULL with new contents when rsp_ready=1 with a grant.
REQ-025 SHALL ignore rsp_ready while EMPTY.
REQ-026 SHALL not make reqi_ready depend on rsp_c/rsp_f; requesters keep valid and payload stable until accepted.
REQ-027 SHALL sustain one accepted operation per cycle when rsp_ready is held at 1.

Reset
REQ-028 SHALL, with rst=1 at a rising edge, force EMPTY (rsp_valid=0), pointer=0, rsp_c=0, rsp_f=0 and rsp_id=0.
REQ-029 SHALL hold req0_ready=req1_ready=0 and alu_a/alu_b/alu_op=0 during any cycle in which rst=1.
REQ-030 SHALL discard a result pending at reset (FULL then rst=1), so it is never presented after reset.

Verification
REQ-031 SHALL pass: req0 only, a=5, b=7, op=ALU_OP_ADD, rsp_ready=1 -> req0_ready=1 in cycle N; rsp_valid=1, rsp_c=12, rsp_id=0 in cycle N+1.
REQ-032 SHALL pass: after reset both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id sequence is 0,1,0,1.
REQ-033 SHALL pass: FULL with rsp_ready=0 for 3 cycles while req1 is valid -> req1_ready=0 and rsp_* unchanged; rsp_ready=1 -> same-cycle req1 grant, new result next cycle.
REQ-034 SHALL pass: req0 SUB-class op with a=b=9 against the bench ALU model -> rsp_c=0 and rsp_f equals the model's flag for that opcode.
REQ-035 SHALL pass: rst=1 while FULL with rsp_id=1 -> next cycle rsp_valid=0; with both valid afterwards the first grant goes to req0.
REQ-036 SHALL pass: back-to-back req1 operations with req0 idle -> req1 granted every cycle, pointer not blocking.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU,
// with a single-entry result register that can drain and refill in one cycle.
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,

    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_c,
    input  logic           alu_f,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_c,
    output logic           rsp_f,
    output logic           rsp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          ptr, ptr_nxt;
    logic          can_accept;
    logic          gnt;
    logic          gnt_id;
    logic [DW-1:0] c_q, c_nxt;
    logic          f_q, f_nxt;
    logic          id_q, id_nxt;

    always_comb begin
        can_accept = (state == EMPTY) || rsp_ready;
        // Grant is suppressed outright during reset so nothing leaks to the ALU.
        gnt        = !rst && can_accept && (req0_valid || req1_valid);
        gnt_id     = (req0_valid && req1_valid) ? ptr : req1_valid;

        req0_ready = gnt && !gnt_id;
        req1_ready = gnt && gnt_id;

        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (req0_ready) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (req1_ready) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end

        state_nxt = state;
        ptr_nxt   = ptr;
        c_nxt     = c_q;
        f_nxt     = f_q;
        id_nxt    = id_q;
        if (gnt) begin
            state_nxt = FULL;
            ptr_nxt   = !gnt_id;
            c_nxt     = alu_c;
            f_nxt     = alu_f;
            id_nxt    = gnt_id;
        end else if (state == FULL && rsp_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            ptr   <= 1'b0;
            c_q   <= '0;
            f_q   <= 1'b0;
            id_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            c_q   <= c_nxt;
            f_q   <= f_nxt;
            id_q  <= id_nxt;
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_c     = c_q;
    assign rsp_f     = f_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: bench-side ALU model, directed scenarios and random
// traffic, all checked every cycle against a transaction-level reference.
module tb_alu_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [OPW-1:0] ALU_OP_SUB = 4'd1;
    localparam logic [OPW-1:0] ALU_OP_AND = 4'd2;
    localparam logic [OPW-1:0] ALU_OP_OR  = 4'd3;
    localparam logic [OPW-1:0] ALU_OP_XOR = 4'd4;
    localparam logic [OPW-1:0] ALU_OP_SLT = 4'd5;

    logic           clk;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;
    logic [DW-1:0]  alu_a, alu_b, alu_c;
    logic [OPW-1:0] alu_op;
    logic           alu_f;
    logic           rsp_valid, rsp_ready;
    logic [DW-1:0]  rsp_c;
    logic           rsp_f, rsp_id;

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .alu_f      (alu_f),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_c      (rsp_c),
        .rsp_f      (rsp_f),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: {flag, result}. SUB-class flag means "operands equal".
    function automatic logic [DW:0] alu_fn(input logic [OPW-1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [DW-1:0] c;
        logic          f;
        case (op)
            ALU_OP_ADD: begin c = a + b;  f = (c == '0); end
            ALU_OP_SUB: begin c = a - b;  f = (a == b);  end
            ALU_OP_AND: begin c = a & b;  f = (c == '0); end
            ALU_OP_OR:  begin c = a | b;  f = (c == '0); end
            ALU_OP_XOR: begin c = a ^ b;  f = (c == '0); end
            ALU_OP_SLT: begin
                f = ($signed(a) < $signed(b));
                c = {{(DW-1){1'b0}}, f};
            end
            default:    begin c = a;      f = 1'b0;      end
        endcase
        return {f, c};
    endfunction

    always_comb {alu_f, alu_c} = alu_fn(alu_op, alu_a, alu_b);

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: what the result register should hold, and whose turn it is.
    logic          m_known = 1'b0;
    logic          m_full  = 1'b0;
    logic          m_ptr   = 1'b0;
    logic [DW-1:0] m_c     = '0;
    logic          m_f     = 1'b0;
    logic          m_id    = 1'b0;

    logic last_g, last_id;
    logic s_r0, s_r1;

    task automatic tick();
        logic          eg, eid;
        logic [DW-1:0] ea, eb;
        logic [OPW-1:0] eop;
        logic [DW:0]   res;
        @(negedge clk);
        eg  = !rst && (!m_full || rsp_ready) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) eid = m_ptr;
        else                          eid = req1_valid;
        ea = '0; eb = '0; eop = '0;
        if (eg) begin
            ea  = eid ? req1_a  : req0_a;
            eb  = eid ? req1_b  : req0_b;
            eop = eid ? req1_op : req0_op;
        end
        s_r0 = req0_ready;
        s_r1 = req1_ready;
        check("req0_ready", 64'(req0_ready), 64'(eg && !eid));
        check("req1_ready", 64'(req1_ready), 64'(eg && eid));
        check("alu_a",  64'(alu_a),  64'(ea));
        check("alu_b",  64'(alu_b),  64'(eb));
        check("alu_op", 64'(alu_op), 64'(eop));
        if (m_known) begin
            check("rsp_valid", 64'(rsp_valid), 64'(m_full));
            if (m_full || rst) begin
                check("rsp_c",  64'(rsp_c),  64'(m_c));
                check("rsp_f",  64'(rsp_f),  64'(m_f));
                check("rsp_id", 64'(rsp_id), 64'(m_id));
            end
        end
        last_g  = eg;
        last_id = eid;
        res = alu_fn(eop, ea, eb);
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_full = 1'b0; m_ptr = 1'b0; m_c = '0; m_f = 1'b0; m_id = 1'b0;
        end else if (eg) begin
            m_full = 1'b1;
            m_c    = res[DW-1:0];
            m_f    = res[DW];
            m_id   = eid;
            m_ptr  = !eid;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_c",     64'(rsp_c),     64'(0));
        check("rst_id",    64'(rsp_id),    64'(0));
    endtask

    task automatic set0(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OPW-1:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OPW-1:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    initial begin
        logic [DW-1:0] held_c;
        logic [DW:0]   ref_sub;
        rst = 1'b1;
        rsp_ready = 1'b0;
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        do_reset();

        // Single req0 ADD: accepted in cycle N, result 12 visible in N+1.
        rsp_ready = 1'b1;
        set0(1'b1, 32'd5, 32'd7, ALU_OP_ADD);
        tick();
        check("add_ready", 64'(s_r0), 64'(1));
        set0(1'b0, '0, '0, '0);
        check("add_valid", 64'(rsp_valid), 64'(1));
        check("add_c",     64'(rsp_c),     64'(12));
        check("add_id",    64'(rsp_id),    64'(0));
        tick();

        // Both valid continuously: grants and response ids alternate 0,1,0,1.
        do_reset();
        rsp_ready = 1'b1;
        set0(1'b1, 32'd1, 32'd2, ALU_OP_ADD);
        set1(1'b1, 32'd3, 32'd4, ALU_OP_XOR);
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            check("alt_grant", 64'(s_r1), 64'(i % 2));
            check("alt_id",    64'(rsp_id), 64'(i % 2));
        end
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        tick();

        // Back-pressure: FULL with rsp_ready low stalls req1, then drains and refills.
        do_reset();
        set0(1'b1, 32'd100, 32'd1, ALU_OP_SUB);
        tick();
        set0(1'b0, '0, '0, '0);
        held_c = rsp_c;
        set1(1'b1, 32'hF0, 32'h0F, ALU_OP_OR);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("stall_r1",  64'(s_r1),   64'(0));
            check("stall_c",   64'(rsp_c),  64'(held_c));
            check("stall_id",  64'(rsp_id), 64'(0));
        end
        check("stall_held", 64'(held_c), 64'(99));
        rsp_ready = 1'b1;
        tick();
        check("drain_r1", 64'(s_r1), 64'(1));
        set1(1'b0, '0, '0, '0);
        check("refill_c",  64'(rsp_c),  64'(32'hFF));
        check("refill_id", 64'(rsp_id), 64'(1));
        tick();

        // SUB with equal operands yields zero and the model's equality flag.
        rsp_ready = 1'b1;
        set0(1'b1, 32'd9, 32'd9, ALU_OP_SUB);
        ref_sub = alu_fn(ALU_OP_SUB, 32'd9, 32'd9);
        tick();
        set0(1'b0, '0, '0, '0);
        check("sub_c", 64'(rsp_c), 64'(0));
        check("sub_f", 64'(rsp_f), 64'(ref_sub[DW]));
        tick();

        // Reset while holding a req1 result discards it and restores req0 priority.
        rsp_ready = 1'b0;
        set1(1'b1, 32'd7, 32'd2, ALU_OP_AND);
        tick();
        set1(1'b0, '0, '0, '0);
        check("pre_rst_id", 64'(rsp_id), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_valid", 64'(rsp_valid), 64'(0));
        set0(1'b1, 32'd1, 32'd1, ALU_OP_ADD);
        set1(1'b1, 32'd2, 32'd2, ALU_OP_ADD);
        tick();
        check("post_rst_first", 64'(s_r0), 64'(1));
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        rsp_ready = 1'b1;
        tick();

        // req1 back-to-back with req0 idle: granted every cycle.
        do_reset();
        rsp_ready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            set1(1'b1, 32'(i), 32'(i + 1), ALU_OP_ADD);
            tick();
            check("b2b_r1", 64'(s_r1), 64'(1));
        end
        set1(1'b0, '0, '0, '0);
        tick();

        // Random traffic: requesters hold payload until accepted.
        for (int unsigned n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid && $urandom_range(0, 2) != 0)
                set0(1'b1, $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 3)),
                     $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 3)),
                     OPW'($urandom_range(0, 7)));
            if (!req1_valid && $urandom_range(0, 2) != 0)
                set1(1'b1, $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 3)),
                     $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 3)),
                     OPW'($urandom_range(0, 7)));
            tick();
            if (last_g && !last_id) req0_valid = 1'b0;
            if (last_g &&  last_id) req1_valid = 1'b0;
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
